// File: rtl/seq_divider_pkg.sv
// -----------------------------------------------------------------------------
// seq_divider_pkg
//   Shared types and sizing helpers for the sequential signed divider.
//   - state_t      : FSM state encoding (IDLE, PREP, ITER, FIX, DONE)
//   - STATE_W      : width of the state encoding
//   - iter_cnt_w() : width of the ITER step counter for an N-bit divider
//   - ITER_CNT_W   : counter width for the default 64-bit build
// -----------------------------------------------------------------------------
package seq_divider_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Counter must hold values up to N, hence $clog2(N+1).
  function automatic int iter_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int ITER_CNT_W = iter_cnt_w(64);

endpackage

// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
//   Multi-cycle two's-complement signed divider (restoring, one quotient bit
//   per cycle). Truncates toward zero; the remainder takes the dividend's sign.
//   Latency from the accepting edge to done is N+2 edges:
//     PREP (1) -> ITER (N) -> FIX (1) -> DONE.
//
//   Optional build macro: DIV_ZERO_CHECK_EN
//     When defined, a zero divisor is caught in PREP, ITER is skipped and the
//     result (quotient = all ones, remainder = dividend, dbz = 1) is ready two
//     edges after acceptance. When undefined, dbz is constantly 0 and a zero
//     divisor runs the normal iteration with don't-care results.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous, active-high reset
//   start      : begin a division (only honoured while busy = 0)
//   dividend   : signed N-bit dividend, captured on the accepting edge
//   divisor    : signed N-bit divisor, captured on the accepting edge
//   busy       : high in PREP, ITER and FIX
//   done       : one-cycle pulse, results valid
//   quotient   : signed N-bit quotient (held until the next result)
//   remainder  : signed N-bit remainder (held until the next result)
//   ovf        : MIN / -1 overflow flag
//   dbz        : divide-by-zero flag
// -----------------------------------------------------------------------------
module seq_signed_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] dividend,
  input  logic signed [N-1:0] divisor,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] quotient,
  output logic signed [N-1:0] remainder,
  output logic                ovf,
  output logic                dbz
);

  localparam int               CNT_W = iter_cnt_w(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);
  localparam logic [N-1:0]     ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     MINV  = {1'b1, {(N-1){1'b0}}};

  // Magnitude as an unsigned N-bit value; MIN maps to 2^(N-1) without loss.
  function automatic logic [N-1:0] mag(input logic signed [N-1:0] v);
    logic [N-1:0] u;
    u = v;
    return v[N-1] ? (~u + ONE) : u;
  endfunction

  // Conditional two's-complement negation of an unsigned magnitude.
  function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v,
                                            input logic       neg);
    return neg ? (~v + ONE) : v;
  endfunction

  state_t state, state_n;
  logic   accept;
  logic   zdiv;

  logic signed [N-1:0] a_r, b_r;
  logic                a_neg, b_neg;
  logic [N-1:0]        q_sh;
  logic [N-1:0]        rem_r;
  logic [N-1:0]        b_mag;
  logic [CNT_W-1:0]    cnt;

  logic [N:0]          pr_sh;
  logic [N:0]          pr_diff;

  logic [N-1:0]        q_fix, r_fix;
  logic                ovf_fix, dbz_fix;

`ifdef DIV_ZERO_CHECK_EN
  assign zdiv = (b_r == '0);
`else
  assign zdiv = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = PREP;
          accept  = 1'b1;
        end
      end
      PREP: begin
        busy    = 1'b1;
        state_n = zdiv ? FIX : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == LAST) state_n = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          state_n = PREP;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // (N+1)-bit working partial remainder: shift in the next dividend bit and
  // trial-subtract; the top bit of the difference is the borrow.
  always_comb begin
    pr_sh   = {rem_r, q_sh[N-1]};
    pr_diff = pr_sh - {1'b0, b_mag};
  end

  // ---- capture -> PREP (magnitudes) -> ITER (restoring steps) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r   <= dividend;
      b_r   <= divisor;
      a_neg <= dividend[N-1];
      b_neg <= divisor[N-1];
    end
    case (state)
      PREP: begin
        q_sh  <= mag(a_r);
        b_mag <= mag(b_r);
        rem_r <= '0;
        cnt   <= '0;
      end
      ITER: begin
        cnt <= cnt + 1'b1;
        if (!pr_diff[N]) begin
          rem_r <= pr_diff[N-1:0];
          q_sh  <= {q_sh[N-2:0], 1'b1};
        end else begin
          rem_r <= pr_sh[N-1:0];
          q_sh  <= {q_sh[N-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  // ---- FIX: sign correction and special cases ----
  always_comb begin
    q_fix   = cond_neg(q_sh, a_neg ^ b_neg);
    r_fix   = cond_neg(rem_r, a_neg);
    // MIN / -1: magnitude 2^(N-1) with positive sign wraps back to MIN.
    ovf_fix = (a_r == MINV) && (b_r == '1);
    dbz_fix = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    if (zdiv) begin
      q_fix   = '1;
      r_fix   = a_r;
      ovf_fix = 1'b0;
      dbz_fix = 1'b1;
    end
`endif
  end

  // ---- FIX -> DONE: results registered, held until the next result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else if (state == FIX) begin
      quotient  <= q_fix;
      remainder <= r_fix;
      ovf       <= ovf_fix;
      dbz       <= dbz_fix;
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_signed_divider
//   Directed bench for seq_signed_divider (N = 64). Expected results are queued
//   when an operation is launched and popped when done is observed.
//   Honours DIV_ZERO_CHECK_EN for the divide-by-zero case.
// -----------------------------------------------------------------------------
module tb_seq_signed_divider;

  localparam int N   = 64;
  localparam int LAT = N + 2;
`ifdef DIV_ZERO_CHECK_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = LAT;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic signed [N-1:0] dividend, divisor;
  logic                busy, done, ovf, dbz;
  logic signed [N-1:0] quotient, remainder;

  localparam logic signed [N-1:0] MINV = {1'b1, {(N-1){1'b0}}};

  seq_signed_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         ovf;
    logic         dbz;
    logic         chkval;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] q, input logic [N-1:0] r,
                      input logic o, input logic z, input logic cv);
    exp_t e;
    e.q = q; e.r = r; e.ovf = o; e.dbz = z; e.chkval = cv;
    sb.push_back(e);
  endtask

  // Present operands at a falling edge; returns 1 ns after the accepting edge.
  task automatic launch(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                        input bit hold);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Called 1 ns after the accepting edge. Counts edges to done, then checks the
  // result against the scoreboard. pulse_at >= 0 injects a start pulse that is
  // sampled on edge t0+pulse_at+1 (while busy).
  task automatic wait_done(input string tag, input int lat, input int pulse_at);
    int   cnt;
    exp_t e;
    cnt = 0;
    chk({tag, " busy@t0"}, N'(busy), N'(1));
    for (int i = 1; i <= lat + 20; i++) begin
      if (i - 1 == pulse_at) begin
        start    = 1'b1;
        dividend = 64'sd9;
        divisor  = 64'sd3;
      end
      @(posedge clk);
      #1;
      if (i - 1 == pulse_at) start = 1'b0;
      if (done) begin
        cnt = i;
        break;
      end
    end
    chk({tag, " latency"}, N'(cnt), N'(lat));
    chk({tag, " busy@done"}, N'(busy), N'(0));
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, N'(0), N'(1));
    end else begin
      e = sb.pop_front();
      if (e.chkval) begin
        chk({tag, " q"}, quotient, e.q);
        chk({tag, " r"}, remainder, e.r);
        chk({tag, " ovf"}, N'(ovf), N'(e.ovf));
      end
      chk({tag, " dbz"}, N'(dbz), N'(e.dbz));
    end
  endtask

  initial begin
    int seen;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    @(posedge clk);
    #2;
    chk("rst busy", N'(busy), N'(0));
    chk("rst done", N'(done), N'(0));
    chk("rst q", quotient, '0);
    chk("rst r", remainder, '0);
    chk("rst ovf", N'(ovf), N'(0));
    chk("rst dbz", N'(dbz), N'(0));

    // First start on the first edge after release: 85 / 10
    push(64'sd8, 64'sd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst      = 1'b0;
    dividend = 64'sd85;
    divisor  = 64'sd10;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("85/10", LAT, -1);
    @(posedge clk);
    #1;
    chk("done one cycle", N'(done), N'(0));
    chk("idle after done", N'(busy), N'(0));
    chk("85/10 hold q", quotient, 64'sd8);

    push(64'sd85, 64'sd0, 1'b0, 1'b0, 1'b1);
    launch(-64'sd850, -64'sd10, 1'b0);
    wait_done("-850/-10", LAT, -1);

    push(-64'sd3, -64'sd1, 1'b0, 1'b0, 1'b1);
    launch(-64'sd7, 64'sd2, 1'b0);
    wait_done("-7/2", LAT, -1);

    push(-64'sd3, 64'sd1, 1'b0, 1'b0, 1'b1);
    launch(64'sd7, -64'sd2, 1'b0);
    wait_done("7/-2", LAT, -1);

    push(64'sd0, 64'sd0, 1'b0, 1'b0, 1'b1);
    launch(64'sd0, 64'sd1234, 1'b0);
    wait_done("0/1234", LAT, -1);

    push(MINV, 64'sd0, 1'b1, 1'b0, 1'b1);
    launch(MINV, -64'sd1, 1'b0);
    wait_done("MIN/-1", LAT, -1);

    push(-64'sd4611686018427387904, 64'sd0, 1'b0, 1'b0, 1'b1);
    launch(MINV, 64'sd2, 1'b0);
    wait_done("MIN/2", LAT, -1);

    push(-64'sd1073741823, -64'sd1, 1'b0, 1'b0, 1'b1);
    launch(-64'sd2147483647, 64'sd2, 1'b0);
    wait_done("-2147483647/2", LAT, -1);

    // Divide by zero
`ifdef DIV_ZERO_CHECK_EN
    push('1, 64'sd5678, 1'b0, 1'b1, 1'b1);
`else
    push('0, '0, 1'b0, 1'b0, 1'b0);
`endif
    launch(64'sd5678, 64'sd0, 1'b0);
    wait_done("5678/0", ZLAT, -1);

    // Start pulsed while busy (sampled at t0+10) must be ignored
    push(64'sd14, 64'sd2, 1'b0, 1'b0, 1'b1);
    launch(64'sd100, 64'sd7, 1'b0);
    wait_done("busy start ignored", LAT, 9);

    // Start held across DONE: back-to-back with no IDLE cycle
    push(64'sd6, 64'sd2, 1'b0, 1'b0, 1'b1);
    push(-64'sd6, -64'sd2, 1'b0, 1'b0, 1'b1);
    launch(64'sd20, 64'sd3, 1'b1);
    wait_done("b2b first", LAT, -1);
    dividend = -64'sd20;
    divisor  = 64'sd3;
    @(posedge clk);
    #1;
    chk("b2b no idle busy", N'(busy), N'(1));
    chk("b2b no idle done", N'(done), N'(0));
    start = 1'b0;
    wait_done("b2b second", LAT, -1);

    // Reset mid-operation at t0+30
    launch(64'sd1000, 64'sd3, 1'b0);
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst busy", N'(busy), N'(0));
    chk("mid rst done", N'(done), N'(0));
    chk("mid rst q", quotient, '0);
    chk("mid rst r", remainder, '0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 10) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("aborted op no done", N'(seen), N'(0));

    push(64'sd20, 64'sd0, 1'b0, 1'b0, 1'b1);
    launch(64'sd100, 64'sd5, 1'b0);
    wait_done("100/5 after rst", LAT, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
SEQ_SIGNED_DIVIDER -- requirements
Module: seq_signed_divider

Interface
REQ-001 The module SHALL have parameter N, default 64, setting the operand and result width in bits (legal N >= 4).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin a division; sampled only when busy=0.
REQ-005 The module SHALL have ports dividend and divisor, input, N bits each: two's-complement signed operands, captured on the edge that accepts start.
REQ-006 The module SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-007 The module SHALL have port done, output, 1 bit: one-cycle pulse marking results valid.
REQ-008 The module SHALL have ports quotient and remainder, output, N bits each: signed results.
REQ-009 The module SHALL have port ovf, output, 1 bit: high for the MIN/-1 result.
REQ-010 The module SHALL have port dbz, output, 1 bit: high for a divide-by-zero result.

Function
REQ-011 The divider SHALL use an FSM with states IDLE, PREP, ITER, FIX and DONE.
REQ-012 Start SHALL be accepted only in IDLE or DONE; start while busy=1 SHALL be ignored and SHALL leave the operation and operands unaffected.
REQ-013 On acceptance at edge t0, the divider SHALL capture the operands and operand signs and enter PREP.
REQ-014 PREP SHALL form operand magnitudes over one cycle.
REQ-015 ITER SHALL perform N restoring shift/subtract steps, one per cycle, using an (N+1)-bit partial remainder.
REQ-016 FIX SHALL apply the sign corrections over one cycle.
REQ-017 The FSM SHALL enter DONE at edge t0+N+2, so latency from the accepting edge to done=1 is N+2 edges.
REQ-018 busy SHALL be 1 in PREP, ITER and FIX, and 0 in IDLE and DONE.
REQ-019 done SHALL be 1 only in DONE, for exactly one cycle; the FSM SHALL go DONE->IDLE, or DONE->PREP if start=1.
REQ-020 Division SHALL truncate toward zero.
REQ-021 Quotient sign SHALL equal sign(dividend) XOR sign(divisor).
REQ-022 Remainder sign SHALL follow the dividend, giving dividend = quotient*divisor + remainder.
REQ-023 The magnitude of the minimum value (-2^(N-1)) SHALL be handled as an unsigned N-bit quantity without loss.
REQ-024 For MIN / -1: quotient=MIN (wrapped), remainder=0, ovf=1.
REQ-025 quotient, remainder, ovf and dbz SHALL update only on entry to DONE and SHALL hold until the next DONE entry or reset.

Reset
REQ-026 rst=1 SHALL force the FSM to IDLE immediately, regardless of clock, including mid-operation.
REQ-027 While rst=1, busy, done, quotient, remainder, ovf and dbz SHALL be 0.
REQ-028 An operation interrupted by reset SHALL be abandoned and SHALL produce no done pulse.
REQ-029 The first start SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-030 With macro DIV_ZERO_CHECK_EN defined, divisor=0 SHALL be detected in PREP, ITER SHALL be skipped, and DONE SHALL be entered at edge t0+2 with quotient=all-ones, remainder=dividend, dbz=1, ovf=0.
REQ-031 Without DIV_ZERO_CHECK_EN, dbz SHALL be tied to 0, divisor=0 SHALL follow the normal N+2 latency, and its quotient/remainder values SHALL be unspecified (bench SHALL check timing only).

Structure
REQ-032 Package seq_divider_pkg SHALL hold the FSM state enum and the localparams for state encoding width and the ITER counter width ($clog2(N+1)).
REQ-033 The block SHALL be a single module with no sub-module; the magnitude and negation logic is inline.

Verification
REQ-034 The bench SHALL cover basic and exact division: 85/10 -> q=8, r=5, done at t0+66 for N=64; -850/-10 -> q=85, r=0.
REQ-035 The bench SHALL cover truncation toward zero: -7/2 -> q=-3, r=-1; 7/-2 -> q=-3, r=1; 0/1234 -> q=0, r=0.
REQ-036 The bench SHALL cover boundary cases: MIN/-1 -> q=MIN, r=0, ovf=1; MIN/2 -> q=-2^62, r=0, ovf=0; -2147483647/2 -> q=-1073741823, r=-1.
REQ-037 The bench SHALL cover divide-by-zero: with DIV_ZERO_CHECK_EN, 5678/0 -> done at t0+2, dbz=1, q=all-ones, r=5678; without it, done at t0+66 and dbz=0.
REQ-038 The bench SHALL cover handshake: start pulsed again at t0+10 with other operands -> ignored, first result unchanged; start held high across DONE -> back-to-back operations with no IDLE cycle.
REQ-039 The bench SHALL cover reset mid-operation: rst asserted at t0+30 -> outputs 0 immediately, no done pulse; a new 100/5 after release -> q=20, r=0.
